trace_buffer_mc: RTL
====================

TRACE_BUFFER_MC -- requirements
Module: trace_buffer_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one trace word.
REQ-002 SHALL have parameter DEPTH, default 512, storage entries; power of two, >= 4; AW = log2(DEPTH).
REQ-003 SHALL have parameter CH, default 4, number of trace source channels, >= 2; SW = max(1, log2(CH)).
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ch_data  input  CH*DATA_W  channel words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port ch_valid  input  CH  per-channel write strobe.
REQ-008 SHALL have port ch_sel  input  SW  selected channel; sampled only when arm is accepted.
REQ-009 SHALL have port mode  input  1  0 = one-shot fill (stop when full), 1 = circular pre/post-trigger capture; sampled when arm is accepted.
REQ-010 SHALL have port post_len  input  AW+1  words to capture after the trigger in mode 1; sampled when arm is accepted.
REQ-011 SHALL have port arm  input  1  start a capture.
REQ-012 SHALL have port trig  input  1  trigger event, one cycle.
REQ-013 SHALL have port rd_req  input  1  read the next stored word.
REQ-014 SHALL have port rd_data  output  DATA_W  read word.
REQ-015 SHALL have port rd_valid  output  1  rd_data is valid this cycle.
REQ-016 SHALL have port count  output  AW+1  words currently stored and unread.
REQ-017 SHALL have port state  output  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
REQ-018 SHALL have port overflow  output  1  sticky flag: mode-1 pre-trigger data was overwritten.

Function
REQ-019 The write strobe SHALL be ch_valid[sel_q] and the write word SHALL be ch_data slice sel_q, where sel_q is the latched ch_sel.
REQ-020 In IDLE, when arm = 1: latch ch_sel, mode and post_len; clear wr_ptr, rd_ptr, count and overflow; go to ARMED next cycle.
REQ-021 ARMED, mode 0: each strobe writes at wr_ptr, and wr_ptr and count increment; when count reaches DEPTH, go to DONE; trig is ignored.
REQ-022 ARMED, mode 1: each strobe writes at wr_ptr and wr_ptr wraps modulo DEPTH.
REQ-023 ARMED, mode 1, storage full: count stays at DEPTH, rd_ptr advances with wr_ptr so that the oldest word is dropped, and overflow sets.
REQ-024 ARMED, mode 1, trig = 1: go to POST with post counter = post_len; a strobe in the same cycle is written as a pre-trigger word.
REQ-025 In POST, each strobe writes as in ARMED and decrements the post counter.
REQ-026 POST SHALL go to DONE when the post counter reaches 0; post_len = 0 SHALL go directly from ARMED to DONE on trig.
REQ-027 The total stored in mode 1 SHALL never exceed DEPTH; post-trigger words overwrite the oldest words.
REQ-028 In DONE, writes SHALL be blocked.
REQ-029 In DONE, rd_req with count > 0 SHALL read mem[rd_ptr]: rd_data and rd_valid appear the next cycle (1-cycle latency), rd_ptr increments with wrap, and count decrements.
REQ-030 rd_req with count = 0, or in any state other than DONE, SHALL be ignored, and rd_valid SHALL be 0 the next cycle.
REQ-031 Readout order SHALL be oldest word first.
REQ-032 DONE SHALL go to IDLE when count = 0 and no read is pending.
REQ-033 arm = 1 in DONE SHALL abort the readout and restart as in REQ-020.
REQ-034 arm = 1 in ARMED or POST SHALL restart the capture as in REQ-020.
REQ-035 Strobes outside ARMED and POST SHALL be ignored; trig outside ARMED SHALL be ignored.
REQ-036 Storage SHALL be a simple dual-port RAM with a registered read, inferable as block RAM.

Reset
REQ-037 On reset: state = IDLE, wr_ptr = rd_ptr = 0, count = 0, post counter = 0, rd_valid = 0, rd_data = 0, overflow = 0, sel_q = 0, mode_q = 0.
REQ-038 Reset asserted mid-capture or mid-readout SHALL take effect immediately; RAM contents are don't-care.

Verification
REQ-039 Scenario, mode-0 fill: DEPTH = 8, ch_sel = 2, arm, then 10 strobes on ch2 with data 1..10 and ch0 active -> state = DONE after the 8th strobe, count = 8, reads return 1..8, then IDLE.
REQ-040 Scenario, mode-1 with wrap: DEPTH = 8, post_len = 3, 12 strobes with data 1..12, trig in the cycle of word 12, then 3 more strobes 13..15 -> overflow = 1, count = 8, reads return 8..15.
REQ-041 Scenario, post_len = 0: trig after 5 words -> DONE the next cycle, count = 5, reads 1..5, overflow = 0.
REQ-042 Scenario, read handshake: back-to-back rd_req for 10 cycles with count = 4 -> exactly 4 rd_valid pulses, each 1 cycle after its request, then rd_valid = 0 and count = 0.
REQ-043 Scenario, reset mid-POST: assert reset -> all outputs at their REQ-037 values in the same cycle; a new arm captures correctly.
REQ-044 Scenario, arm during DONE with count = 3 -> count = 0, state = ARMED the next cycle, overflow cleared.

Source files
------------

// File: rtl/trace_buffer_mc.sv
// Multi-channel trace capture buffer: one-shot fill or circular pre/post-trigger
// capture of a selected channel into a simple dual-port RAM, read back oldest-first.
module trace_buffer_mc #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int CH     = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH*DATA_W-1:0] ch_data,
  input  logic [CH-1:0]        ch_valid,
  input  logic [SW-1:0]        ch_sel,
  input  logic                 mode,
  input  logic [AW:0]          post_len,
  input  logic                 arm,
  input  logic                 trig,
  input  logic                 rd_req,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic [AW:0]          count,
  output logic [1:0]           state,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t              state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                mode_q, mode_d;
  logic [AW:0]         post_len_q, post_len_d;
  logic [AW:0]         post_cnt_q, post_cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_en, rd_fire;
  logic                strobe;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign strobe  = ch_valid[sel_q];
  assign wr_word = ch_data[sel_q*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    post_len_d = post_len_q;
    post_cnt_d = post_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;
    rd_fire    = 1'b0;
    // arm wins in every state: it starts (or restarts) a capture from scratch
    if (arm) begin
      state_d    = S_ARMED;
      sel_d      = ch_sel;
      mode_d     = mode;
      post_len_d = post_len;
      post_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          if (strobe) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            // full circular buffer: drop the oldest word instead of growing
            if (count_q == FULL) begin
              rd_ptr_d   = rd_ptr_q + PTR_ONE;
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
            if (state_q == S_POST) post_cnt_d = post_cnt_q - CNT_ONE;
          end
          if (state_q == S_ARMED) begin
            if (!mode_q) begin
              if (count_d == FULL) state_d = S_DONE;
            end else if (trig) begin
              if (post_len_q == '0) begin
                state_d = S_DONE;
              end else begin
                state_d    = S_POST;
                post_cnt_d = post_len_q;
              end
            end
          end else if (post_cnt_d == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_req && (count_q != '0)) begin
            rd_fire    = 1'b1;
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            count_d    = count_q - CNT_ONE;
          end else if (count_q == '0) begin
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      mode_q     <= 1'b0;
      post_len_q <= '0;
      post_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      post_len_q <= post_len_d;
      post_cnt_q <= post_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      if (rd_fire) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // RAM write port carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule
